dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_pkg.sv | 58 +++++
 rtl/dcache_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped data cache controller.
// Contents:
//   state_t  - controller FSM states
//   line_t   - external line array layout {valid, tag, data}
//   req_t    - latched request (tag/index split out of the address)
//   mk_line  - builds a valid line from tag + data
package dcache_pkg;

   localparam int ADDR_W    = 64;
   localparam int DATA_W    = 64;
   localparam int TAG_W     = 56;
   localparam int INDEX_W   = 5;
   localparam int OFFS_W    = 3;
   localparam int LINE_W    = 1 + TAG_W + DATA_W;   // 121

   // Field positions inside a line word
   localparam int VALID_POS = 120;
   localparam int TAG_HI    = 119;
   localparam int TAG_LO    = 64;
   localparam int DATA_HI   = 63;
   localparam int DATA_LO   = 0;

   // Address split
   localparam int INDEX_LO  = OFFS_W;               // addr[7:3]
   localparam int TAG_POS   = OFFS_W + INDEX_W;     // addr[63:8]

   typedef enum logic [2:0] {
      FLUSH,
      IDLE,
      LOOKUP,
      MEM_REQ,
      MEM_WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } line_t;

   typedef struct packed {
      logic               we;
      logic [TAG_W-1:0]   tag;
      logic [INDEX_W-1:0] index;
      logic [DATA_W-1:0]  wdata;
   } req_t;

   function automatic line_t mk_line(input logic [TAG_W-1:0]  tag,
                                     input logic [DATA_W-1:0] data);
      line_t l;
      l.valid = 1'b1;
      l.tag   = tag;
      l.data  = data;
      return l;
   endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One request outstanding; the line array itself is external (1-cycle read).
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_*                 - load/store request (valid/ready handshake)
//   resp_valid/resp_data  - one-cycle completion pulse, no backpressure
//   flush/flush_done      - invalidate-all request / one-cycle completion pulse
//   arr_*                 - external line array: index, read line, write enable/line
//   mem_req_*/mem_resp_*  - backing memory request/response
//   hit, update, update_data - debug-monitor taps
//   hit_cnt, miss_cnt     - lookup counters, present only with DCACHE_PERF_EN
//
// Configuration macro: DCACHE_PERF_EN (adds hit/miss counters and their ports).
// After reset the controller walks all lines invalidating them before it
// accepts requests.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int LINES = 32
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_data,
   input  logic                flush,
   output logic                flush_done,
   output logic [INDEX_W-1:0]  arr_index,
   input  logic [LINE_W-1:0]   arr_line,
   output logic                arr_we,
   output logic [LINE_W-1:0]   arr_wline,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_req_we,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic [DATA_W-1:0]   mem_req_wdata,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data,
   output logic                hit,
   output logic                update,
`ifdef DCACHE_PERF_EN
   output logic [31:0]         hit_cnt,
   output logic [31:0]         miss_cnt,
`endif
   output logic [DATA_W-1:0]   update_data
);

   localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(LINES - 1);
   localparam logic [INDEX_W-1:0] IDX_ONE  = INDEX_W'(1);

   state_t             state, state_n;
   logic [INDEX_W-1:0] flush_cnt;
   req_t               req_q;
   line_t              rd_line;
   logic               lookup_hit;

   // Byte offset never matters: accesses are whole 64-bit words.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^req_addr[OFFS_W-1:0];

   assign rd_line    = line_t'(arr_line);
   assign lookup_hit = rd_line.valid && (rd_line.tag == req_q.tag);

   // Memory side is driven straight from the latched request, so addr/we/wdata
   // stay stable for as long as MEM_REQ waits on mem_req_ready.
   assign mem_req_we    = req_q.we;
   assign mem_req_addr  = {req_q.tag, req_q.index, {OFFS_W{1'b0}}};
   assign mem_req_wdata = req_q.wdata;

   assign update      = arr_we;
   assign update_data = arr_wline[DATA_HI:DATA_LO];

   always_comb begin
      state_n       = state;
      req_ready     = 1'b0;
      arr_index     = req_q.index;
      arr_we        = 1'b0;
      arr_wline     = '0;
      hit           = 1'b0;
      mem_req_valid = 1'b0;
      resp_valid    = 1'b0;
      case (state)
         FLUSH: begin
            arr_index = flush_cnt;
            arr_we    = 1'b1;
            if (flush_cnt == LAST_IDX) state_n = IDLE;
         end
         IDLE: begin
            // Array read is launched on the accept cycle so the line is
            // available in LOOKUP.
            arr_index = req_addr[INDEX_LO +: INDEX_W];
            req_ready = !flush;
            if (flush)          state_n = FLUSH;
            else if (req_valid) state_n = LOOKUP;
         end
         LOOKUP: begin
            hit = lookup_hit;
            if (req_q.we) begin
               // Write-through: update the line only on a hit, always go to memory.
               if (lookup_hit) begin
                  arr_we    = 1'b1;
                  arr_wline = mk_line(req_q.tag, req_q.wdata);
               end
               state_n = MEM_REQ;
            end else begin
               state_n = lookup_hit ? RESP : MEM_REQ;
            end
         end
         MEM_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_n = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (mem_resp_valid) begin
               if (!req_q.we) begin
                  arr_we    = 1'b1;
                  arr_wline = mk_line(req_q.tag, mem_resp_data);
               end
               state_n = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            state_n    = IDLE;
         end
         default: state_n = FLUSH;
      endcase
      // Reset aborts whatever is in flight; nothing leaks out during it.
      if (rst) begin
         state_n       = FLUSH;
         req_ready     = 1'b0;
         arr_we        = 1'b0;
         arr_wline     = '0;
         hit           = 1'b0;
         mem_req_valid = 1'b0;
         resp_valid    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FLUSH;
         flush_cnt  <= '0;
         req_q      <= '0;
         resp_data  <= '0;
         flush_done <= 1'b0;
      end else begin
         state      <= state_n;
         flush_done <= (state == FLUSH) && (flush_cnt == LAST_IDX);
         // Counter wraps back to 0 after the last line, ready for the next flush.
         if (state == FLUSH) flush_cnt <= flush_cnt + IDX_ONE;
         if (req_valid && req_ready) begin
            req_q.we    <= req_we;
            req_q.tag   <= req_addr[ADDR_W-1:TAG_POS];
            req_q.index <= req_addr[INDEX_LO +: INDEX_W];
            req_q.wdata <= req_wdata;
         end
         if (state == LOOKUP && !req_q.we && lookup_hit)
            resp_data <= rd_line.data;
         if (state == MEM_WAIT && mem_resp_valid)
            resp_data <= req_q.we ? '0 : mem_resp_data;
      end
   end

`ifdef DCACHE_PERF_EN
   // Cleared only by reset; a flush leaves the statistics alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state == LOOKUP) begin
         if (lookup_hit) hit_cnt  <= hit_cnt + 32'd1;
         else            miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl with a response scoreboard.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dcache_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we;
   logic [63:0]   req_addr, req_wdata;
   logic          resp_valid;
   logic [63:0]   resp_data;
   logic          flush, flush_done;
   logic [4:0]    arr_index;
   logic [120:0]  arr_line;
   logic          arr_we;
   logic [120:0]  arr_wline;
   logic          mem_req_valid, mem_req_ready, mem_req_we;
   logic [63:0]   mem_req_addr, mem_req_wdata;
   logic          mem_resp_valid;
   logic [63:0]   mem_resp_data;
   logic          hit, update;
   logic [63:0]   update_data;
`ifdef DCACHE_PERF_EN
   logic [31:0]   hit_cnt, miss_cnt;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   dcache_ctrl #(.LINES(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .flush(flush), .flush_done(flush_done),
      .arr_index(arr_index), .arr_line(arr_line), .arr_we(arr_we), .arr_wline(arr_wline),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .hit(hit), .update(update),
`ifdef DCACHE_PERF_EN
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
      .update_data(update_data)
   );

   // External line array: registered read, write on arr_we.
   logic [120:0] arr_mem [32];
   always @(posedge clk) begin
      arr_line <= arr_mem[arr_index];
      if (arr_we) arr_mem[arr_index] <= arr_wline;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every response pulse must match the oldest expected value.
   always @(posedge clk) begin
      #1;
      if (resp_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
         else chk("resp_data", resp_data, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Called on a falling edge right after reset / flush trigger is released;
   // checks 32 invalidating writes then the done pulse.
   task automatic check_flush(input bit stray);
      if (stray) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = 64'hBAD0_BAD0;
      end
      #1;
      for (int i = 0; i < 32; i++) begin
         chk("flush_we", arr_we, 1);
         chk("flush_idx", arr_index, i);
         chk("flush_wline", arr_wline, 0);
         chk("flush_ready", req_ready, 0);
         chk("flush_no_resp", resp_valid, 0);
         @(negedge clk);
         mem_resp_valid = 1'b0;
         #1;
      end
      chk("flush_done", flush_done, 1);
      chk("ready_after_flush", req_ready, 1);
   endtask

   task automatic do_req(input bit we, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] md, input int rdy_dly,
                         input bit exp_hit, input bit exp_mem, input logic [63:0] exp_resp);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
      #1;
      chk("accept_ready", req_ready, 1);
      chk("accept_idx", arr_index, a[7:3]);
      exp_q.push_back(exp_resp);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("lookup_hit", hit, exp_hit);
      chk("lookup_we", arr_we, we & exp_hit);
      if (we && exp_hit) begin
         chk("lookup_wline", arr_wline, {1'b1, a[63:8], wd});
         chk("lookup_update", update_data, wd);
      end
      if (!exp_mem) begin
         @(negedge clk); #1;
         chk("hit_resp_valid", resp_valid, 1);
         chk("hit_no_mem", mem_req_valid, 0);
      end else begin
         @(negedge clk);
         mem_req_ready = 1'b0;
         #1;
         for (int k = 0; k < rdy_dly; k++) begin
            chk("memreq_hold_valid", mem_req_valid, 1);
            chk("memreq_hold_addr", mem_req_addr, {a[63:3], 3'b000});
            @(negedge clk); #1;
         end
         chk("memreq_valid", mem_req_valid, 1);
         chk("memreq_addr", mem_req_addr, {a[63:3], 3'b000});
         chk("memreq_we", mem_req_we, we);
         if (we) chk("memreq_wdata", mem_req_wdata, wd);
         mem_req_ready = 1'b1;
         @(negedge clk);
         mem_req_ready = 1'b0;
         #1;
         chk("memwait_no_valid", mem_req_valid, 0);
         @(negedge clk); #1;
         chk("memwait_no_resp", resp_valid, 0);
         @(negedge clk);
         mem_resp_valid = 1'b1; mem_resp_data = md;
         #1;
         chk("fill_we", arr_we, !we);
         if (!we) begin
            chk("fill_idx", arr_index, a[7:3]);
            chk("fill_wline", arr_wline, {1'b1, a[63:8], md});
            chk("fill_update", update, 1);
            chk("fill_update_data", update_data, md);
         end
         @(negedge clk);
         mem_resp_valid = 1'b0;
         #1;
         chk("mem_resp_valid", resp_valid, 1);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) arr_mem[i] = '1;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_arr_we", arr_we, 0);
      chk("rst_hit", hit, 0);
      chk("rst_update", update, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_mem_req_addr", mem_req_addr, 0);
      chk("rst_req_ready", req_ready, 0);
`ifdef DCACHE_PERF_EN
      chk("rst_hit_cnt", hit_cnt, 0);
      chk("rst_miss_cnt", miss_cnt, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      check_flush(0);

      // Load miss then hit, store hit, load of stored data
      do_req(0, 64'h1000_0040, 0, 64'hDEAD_BEEF, 0, 0, 1, 64'hDEAD_BEEF);
      do_req(0, 64'h1000_0040, 0, 0, 0, 1, 0, 64'hDEAD_BEEF);
      do_req(1, 64'h1000_0040, 64'h55, 0, 0, 1, 1, 64'h0);
      do_req(0, 64'h1000_0040, 0, 0, 0, 1, 0, 64'h55);
      // Store miss (no allocate) with slow mem_req_ready, then load misses
      do_req(1, 64'h2000_0000, 64'hA5A5, 0, 5, 0, 1, 64'h0);
      do_req(0, 64'h2000_0000, 0, 64'h1234, 2, 0, 1, 64'h1234);
      // Same index, different tag evicts the line
      do_req(0, 64'h3000_0040, 0, 64'h77, 0, 0, 1, 64'h77);
      do_req(0, 64'h1000_0040, 0, 64'h99, 1, 0, 1, 64'h99);

      // Flush and request in the same IDLE cycle: flush wins
      @(negedge clk);
      flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h1000_0040;
      #1;
      chk("flush_beats_req", req_ready, 0);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      check_flush(0);
      do_req(0, 64'h1000_0040, 0, 64'h4242, 0, 0, 1, 64'h4242);
`ifdef DCACHE_PERF_EN
      chk("perf_hit_cnt", hit_cnt, 3);
      chk("perf_miss_cnt", miss_cnt, 6);
`endif

      // Reset during MEM_WAIT aborts the load
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h3000_0088;
      #1;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("abort_lookup_miss", hit, 0);
      @(negedge clk);
      mem_req_ready = 1'b1;
      #1;
      chk("abort_memreq", mem_req_valid, 1);
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort_rst_no_resp", resp_valid, 0);
      chk("abort_rst_no_memreq", mem_req_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      check_flush(1);
`ifdef DCACHE_PERF_EN
      chk("abort_hit_cnt", hit_cnt, 0);
      chk("abort_miss_cnt", miss_cnt, 0);
`endif
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
